// File: rtl/nmr_bitstream_pulse_gen.sv
// rtl/nmr_bitstream_pulse_gen.sv - one-segment delay/pulse/delay player for the NMR sequencer handshake
module nmr_bitstream_pulse_gen #(
    parameter int   IDLY_WIDTH = 32,
    parameter int   PLS_WIDTH  = 32,
    parameter int   EDLY_WIDTH = 32,
    parameter logic PLS_ACTIVE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BT_START,
    output logic                  BT_DONE,
    input  logic [IDLY_WIDTH-1:0] idly_reg,
    input  logic [PLS_WIDTH-1:0]  pls_reg,
    input  logic [EDLY_WIDTH-1:0] edly_reg,
    output logic                  PLS_OUT,
    output logic                  BUSY_START_ERR,
    input  logic                  ERR_CLR
);

    localparam int CW_A = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
    localparam int CW   = (CW_A > EDLY_WIDTH) ? CW_A : EDLY_WIDTH;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_IDLY,
        S_PLS,
        S_EDLY
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] idly_q;
    logic [CW-1:0] pls_q;
    logic [CW-1:0] edly_q;
    logic          accept;
    logic          busy_start;

    assign accept     = BT_START && (state == S_IDLE);
    assign busy_start = BT_START && (state != S_IDLE);

    // Counter holds (len-1) on phase entry so a phase of len cycles ends when it reads zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (BT_START) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (idly_q != ZERO) begin
                    state_next = S_IDLY;
                    cnt_next   = idly_q - ONE;
                end else if (pls_q != ZERO) begin
                    state_next = S_PLS;
                    cnt_next   = pls_q - ONE;
                end else if (edly_q != ZERO) begin
                    state_next = S_EDLY;
                    cnt_next   = edly_q - ONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_IDLY: begin
                if (cnt != ZERO) begin
                    cnt_next = cnt - ONE;
                end else if (pls_q != ZERO) begin
                    state_next = S_PLS;
                    cnt_next   = pls_q - ONE;
                end else if (edly_q != ZERO) begin
                    state_next = S_EDLY;
                    cnt_next   = edly_q - ONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_PLS: begin
                if (cnt != ZERO) begin
                    cnt_next = cnt - ONE;
                end else if (edly_q != ZERO) begin
                    state_next = S_EDLY;
                    cnt_next   = edly_q - ONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_EDLY: begin
                if (cnt != ZERO) cnt_next = cnt - ONE;
                else             state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            cnt            <= ZERO;
            idly_q         <= ZERO;
            pls_q          <= ZERO;
            edly_q         <= ZERO;
            BT_DONE        <= 1'b1;
            PLS_OUT        <= ~PLS_ACTIVE;
            BUSY_START_ERR <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            BT_DONE <= (state_next == S_IDLE);
            PLS_OUT <= (state_next == S_PLS) ? PLS_ACTIVE : ~PLS_ACTIVE;
            if (accept) begin
                idly_q <= CW'(idly_reg);
                pls_q  <= CW'(pls_reg);
                edly_q <= CW'(edly_reg);
            end
            if (busy_start)   BUSY_START_ERR <= 1'b1;
            else if (ERR_CLR) BUSY_START_ERR <= 1'b0;
        end
    end

endmodule

// File: doc/nmr_bitstream_pulse_gen.md
Name: nmr_bitstream_pulse_gen

Overview:
Responder for the NMR command sequencer's bitstream handshake. Accepts a one-cycle BT_START with {idly, pls, edly} timing words and plays out one segment on PLS_OUT: initial delay low, pulse high, post-pulse delay low. BT_DONE is a level "ready" flag. The sequencer samples it before issuing the next segment, so back-to-back segments chain without gaps beyond the handshake overhead.

Parameters:
IDLY_WIDTH, 32, initial delay width (clock cycles)
PLS_WIDTH, 32, pulse length width (clock cycles)
EDLY_WIDTH, 32, post-pulse delay width (clock cycles)
PLS_ACTIVE, 1'b1, PLS_OUT level during the pulse phase; the idle level is its inverse

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
BT_START  in  1  segment start strobe, sampled on CLK rising edge
BT_DONE  out  1  high = idle/ready; low while a segment plays
idly_reg  in  IDLY_WIDTH  initial delay length; sampled only with an accepted BT_START
pls_reg  in  PLS_WIDTH  pulse length; sampled only with an accepted BT_START
edly_reg  in  EDLY_WIDTH  post-pulse delay length; sampled only with an accepted BT_START
PLS_OUT  out  1  pulse output to the TX gate
BUSY_START_ERR  out  1  sticky flag: BT_START seen while busy
ERR_CLR  in  1  synchronous clear of BUSY_START_ERR

Behaviour:
- Reset (async, immediate): state IDLE, BT_DONE=1, PLS_OUT=~PLS_ACTIVE, BUSY_START_ERR=0, counter and latches cleared. Reset mid-segment aborts the segment at once; no pulse residue.
- All outputs are registered.
- States: IDLE, LOAD, IDLY, PLS, EDLY.
- IDLE:
  - BT_DONE=1.
  - BT_START=1 at edge k latches idly/pls/edly, sets BT_DONE=0 and goes to LOAD.
  - BT_DONE is therefore low from edge k, i.e. visible one cycle after the strobe. The sequencer needs at least 4 cycles before it re-polls.
- LOAD (exactly 1 cycle): go to the first non-zero phase in the order IDLY, PLS, EDLY. If all three are zero, return to IDLE with BT_DONE=1.
- Phase states: a single down-counter loaded with (len-1) on phase entry. Each phase lasts exactly len cycles, then moves to the next non-zero phase, or to IDLE if none remain. Zero-length phases are skipped and consume no cycles.
- PLS_OUT: equals PLS_ACTIVE exactly while in PLS, otherwise ~PLS_ACTIVE. The level is registered on the state transition so the pulse carries no glitch.
- Timing from strobe edge k:
  - BT_DONE low for exactly 1+idly+pls+edly cycles.
  - PLS_OUT active over edges k+1+idly to k+1+idly+pls.
- Widths: counter width = max of the three widths. Lengths are unsigned; full scale 2^W-1 is legal and must not wrap.
- Returning to IDLE reasserts BT_DONE=1. A BT_START on that same edge is not accepted; it is accepted on the following edge.
- BT_START while not IDLE:
  - ignored; the segment is unaffected and the inputs are not relatched;
  - sets BUSY_START_ERR.
- BUSY_START_ERR: ERR_CLR clears it. If a set and ERR_CLR occur in the same cycle, the set wins.
- BT_START held high across several cycles: only the IDLE-cycle sample starts a segment; later cycles count as busy starts and raise the error.

Test Plan:
- Reset then idle, 10 cycles → BT_DONE=1, PLS_OUT=0, BUSY_START_ERR=0.
- idly=3, pls=5, edly=2, strobe at edge k:
  - BT_DONE low over k..k+10, high at k+11;
  - PLS_OUT high for exactly 5 cycles starting at edge k+4.
- Zero-length cases:
  - idly=0, pls=4, edly=0 → PLS_OUT high from k+1 for 4 cycles; BT_DONE high at k+5.
  - 0/0/0 → BT_DONE low for 1 cycle only; PLS_OUT never active.
- Busy start: strobe during PLS with new values 1/1/1 → original 3/5/2 timing unchanged and BUSY_START_ERR=1. ERR_CLR pulse → 0. A simultaneous set and clear leaves 1.
- Back-to-back: second strobe 5 cycles after BT_DONE rises, values 0/2/0 → second pulse width 2, same 1-cycle BT_DONE fall latency. Repeat with PLS_ACTIVE=0 → output inverted.
- Abort: assert RST mid-IDLY and mid-PLS → outputs reach reset values immediately; no pulse after RST release without a new strobe.
